// File: rtl/eth_frame_reader.sv
// eth_frame_reader
//   Pulls one frame at a time out of an external length FIFO / data FIFO pair
//   and replays it as a valid/ready byte stream.
//   Frames whose length is outside [MIN_LEN, MAX_LEN] are read out and
//   discarded. Length reads that never complete are abandoned after
//   LEN_TIMEOUT cycles. Both of these cases count as drops.
//
// Ports
//   i_sys_clk, i_rstn        clock, synchronous active-low reset
//   i_len_fifo_*             length FIFO status and read data (r_done qualifies data)
//   o_len_fifo_r_en/_r_line  one-line length read request
//   i_data_fifo_*            data FIFO status and read data (valid one cycle after a request)
//   o_data_fifo_r_en/_r_stop read window for the current frame and per-cycle request gate
//   o_data_fifo_r_line       length of the current frame, in lines
//   o_frame_*/i_frame_ready  output byte stream with sof/eof markers
//   o_frame_err              one-cycle pulse per dropped frame
//   o_frame_cnt/o_drop_cnt   wrapping counts of delivered and dropped frames
//   o_busy                   high whenever the reader is not idle
module eth_frame_reader #(
    parameter int DATA_WIDTH  = 8,
    parameter int LEN_WIDTH   = 11,
    parameter int MIN_LEN     = 64,
    parameter int MAX_LEN     = 1518,
    parameter int DATA_DEPTH  = 12144,
    parameter int LEN_DEPTH   = 190,
    parameter int LEN_TIMEOUT = 255,
    localparam int DL = $clog2(DATA_DEPTH),
    localparam int LL = $clog2(LEN_DEPTH)
) (
    input  logic                  i_sys_clk,
    input  logic                  i_rstn,
    input  logic                  i_len_fifo_empty,
    input  logic                  i_len_fifo_r_done,
    input  logic [LEN_WIDTH-1:0]  i_len_fifo_data,
    output logic                  o_len_fifo_r_en,
    output logic [LL-1:0]         o_len_fifo_r_line,
    input  logic                  i_data_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_data_fifo_data,
    output logic                  o_data_fifo_r_en,
    output logic                  o_data_fifo_r_stop,
    output logic [DL-1:0]         o_data_fifo_r_line,
    output logic [DATA_WIDTH-1:0] o_frame_data,
    output logic                  o_frame_valid,
    output logic                  o_frame_sof,
    output logic                  o_frame_eof,
    input  logic                  i_frame_ready,
    output logic                  o_frame_err,
    output logic [15:0]           o_frame_cnt,
    output logic [15:0]           o_drop_cnt,
    output logic                  o_busy
);
    localparam int TW = $clog2(LEN_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LEN_REQ, LEN_WAIT, CHECK, DATA, DROP} state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  rem_req_q, rem_req_d;
    logic [LEN_WIDTH-1:0]  rem_out_q, rem_out_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic                  err_q, err_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;

    logic                  rd_phase;
    logic                  pop;
    logic                  push;
    logic                  stop;
    logic                  issue;
    logic [2:0]            fill;

    // Request gating. fill is the skid occupancy once the line already in
    // flight has landed and this cycle's pop has left; a new request would
    // land on top of that, so it is only allowed while fill is below 2.
    // Outside DATA/DROP there is no read window, so stop is held low.
    always_comb begin
        rd_phase = (state_q == DATA) || (state_q == DROP);
        pop      = (state_q == DATA) && (occ_q != 2'd0) && i_frame_ready;
        push     = (state_q == DATA) && inflight_q;
        fill     = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        stop     = rd_phase && ((rem_req_q == '0) || i_data_fifo_empty ||
                                ((state_q == DATA) && (fill >= 3'd2)));
        issue    = rd_phase && !stop;
    end

    // Next-state, frame bookkeeping and skid buffer update.
    // In DROP, rem_out counts returned lines rather than transferred bytes,
    // so the frame ends exactly when the last requested line comes back.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        rem_req_d   = rem_req_q;
        rem_out_d   = rem_out_q;
        tmo_d       = tmo_q;
        inflight_d  = issue;
        occ_d       = occ_q;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        err_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;

        if (issue) begin
            rem_req_d = rem_req_q - LEN_WIDTH'(1);
        end
        if (pop) begin
            rem_out_d = rem_out_q - LEN_WIDTH'(1);
        end
        if ((state_q == DROP) && inflight_q && (rem_out_q != '0)) begin
            rem_out_d = rem_out_q - LEN_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (!i_len_fifo_empty) begin
                    state_d = LEN_REQ;
                end
            end
            LEN_REQ: begin
                tmo_d   = '0;
                state_d = LEN_WAIT;
            end
            LEN_WAIT: begin
                if (i_len_fifo_r_done) begin
                    len_d   = i_len_fifo_data;
                    state_d = CHECK;
                end else if (tmo_q == TW'(LEN_TIMEOUT - 1)) begin
                    err_d      = 1'b1;
                    drop_cnt_d = drop_cnt_q + 16'd1;
                    state_d    = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            CHECK: begin
                rem_req_d = len_q;
                rem_out_d = len_q;
                if ((len_q >= LEN_WIDTH'(MIN_LEN)) && (len_q <= LEN_WIDTH'(MAX_LEN))) begin
                    state_d = DATA;
                end else begin
                    state_d = DROP;
                end
            end
            DATA: begin
                if (pop && (rem_out_q == LEN_WIDTH'(1))) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            DROP: begin
                // A zero-length frame has nothing to read back, so it ends at once.
                if ((rem_out_q == '0) || (inflight_q && (rem_out_q == LEN_WIDTH'(1)))) begin
                    err_d      = 1'b1;
                    drop_cnt_d = drop_cnt_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Two-entry skid buffer; buf0 is always the oldest entry.
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    buf0_d = i_data_fifo_data;
                end else begin
                    buf1_d = i_data_fifo_data;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d = i_data_fifo_data;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = i_data_fifo_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (!i_rstn) begin
            state_q     <= IDLE;
            len_q       <= '0;
            rem_req_q   <= '0;
            rem_out_q   <= '0;
            tmo_q       <= '0;
            inflight_q  <= 1'b0;
            occ_q       <= 2'd0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            err_q       <= 1'b0;
            frame_cnt_q <= 16'd0;
            drop_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            rem_req_q   <= rem_req_d;
            rem_out_q   <= rem_out_d;
            tmo_q       <= tmo_d;
            inflight_q  <= inflight_d;
            occ_q       <= occ_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // sof/eof are derived from the transfer countdown, which only moves on a
    // transfer, so they stay stable while the consumer stalls.
    always_comb begin
        o_len_fifo_r_en    = (state_q == LEN_REQ);
        o_len_fifo_r_line  = (state_q == LEN_REQ) ? LL'(1) : '0;
        o_data_fifo_r_en   = rd_phase;
        o_data_fifo_r_stop = stop;
        o_data_fifo_r_line = rd_phase ? DL'(len_q) : '0;
        o_frame_valid      = (occ_q != 2'd0);
        o_frame_data       = buf0_q;
        o_frame_sof        = o_frame_valid && (rem_out_q == len_q);
        o_frame_eof        = o_frame_valid && (rem_out_q == LEN_WIDTH'(1));
        o_frame_err        = err_q;
        o_frame_cnt        = frame_cnt_q;
        o_drop_cnt         = drop_cnt_q;
        o_busy             = (state_q != IDLE);
    end

endmodule

// File: tb/tb_eth_frame_reader.sv
// tb_eth_frame_reader
//   Drives eth_frame_reader with behavioural length/data FIFO models and a
//   scoreboard of the byte stream that the accepted frames should produce.
//   Length reads complete one cycle after the request; data lines arrive one
//   cycle after each granted request.
module tb_eth_frame_reader;
    localparam int LW = 11;
    localparam int DL = $clog2(12144);
    localparam int LL = $clog2(190);

    logic            clk = 1'b0;
    logic            i_rstn;
    logic            i_len_fifo_empty;
    logic            i_len_fifo_r_done;
    logic [LW-1:0]   i_len_fifo_data;
    logic            o_len_fifo_r_en;
    logic [LL-1:0]   o_len_fifo_r_line;
    logic            i_data_fifo_empty;
    logic [7:0]      i_data_fifo_data;
    logic            o_data_fifo_r_en;
    logic            o_data_fifo_r_stop;
    logic [DL-1:0]   o_data_fifo_r_line;
    logic [7:0]      o_frame_data;
    logic            o_frame_valid;
    logic            o_frame_sof;
    logic            o_frame_eof;
    logic            i_frame_ready;
    logic            o_frame_err;
    logic [15:0]     o_frame_cnt;
    logic [15:0]     o_drop_cnt;
    logic            o_busy;

    always #5 clk = ~clk;

    eth_frame_reader dut (
        .i_sys_clk          (clk),
        .i_rstn             (i_rstn),
        .i_len_fifo_empty   (i_len_fifo_empty),
        .i_len_fifo_r_done  (i_len_fifo_r_done),
        .i_len_fifo_data    (i_len_fifo_data),
        .o_len_fifo_r_en    (o_len_fifo_r_en),
        .o_len_fifo_r_line  (o_len_fifo_r_line),
        .i_data_fifo_empty  (i_data_fifo_empty),
        .i_data_fifo_data   (i_data_fifo_data),
        .o_data_fifo_r_en   (o_data_fifo_r_en),
        .o_data_fifo_r_stop (o_data_fifo_r_stop),
        .o_data_fifo_r_line (o_data_fifo_r_line),
        .o_frame_data       (o_frame_data),
        .o_frame_valid      (o_frame_valid),
        .o_frame_sof        (o_frame_sof),
        .o_frame_eof        (o_frame_eof),
        .i_frame_ready      (i_frame_ready),
        .o_frame_err        (o_frame_err),
        .o_frame_cnt        (o_frame_cnt),
        .o_drop_cnt         (o_drop_cnt),
        .o_busy             (o_busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       sof;
        logic       eof;
    } beat_t;

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    logic [7:0]  data_model[$];
    int          len_model[$];
    beat_t       exp_q[$];
    int          ready_mode = 0;
    logic        hold_done = 1'b0;
    int          exp_frames = 0;
    int          exp_drops = 0;
    int          err_seen, xfer_cnt, first_xfer, last_xfer, stop_seen;
    int          last_eof_cycle, sof_gap, rline_seen, lline_seen;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearStats();
        err_seen       = 0;
        xfer_cnt       = 0;
        first_xfer     = 0;
        last_xfer      = 0;
        stop_seen      = 0;
        last_eof_cycle = -1;
        sof_gap        = -1;
        rline_seen     = 0;
        lline_seen     = 0;
    endtask

    // Queue one frame: its length into the length FIFO, its bytes into the
    // data FIFO, and, only when the length is legal, its bytes into the
    // expected output stream.
    task automatic applyStimulus(input int len, input bit incrementing);
        logic [7:0] b;
        beat_t      bt;
        bit         legal;
        legal = (len >= 64) && (len <= 1518);
        len_model.push_back(len);
        for (int i = 0; i < len; i++) begin
            b = incrementing ? 8'(i) : 8'($urandom);
            data_model.push_back(b);
            if (legal) begin
                bt.data = b;
                bt.sof  = (i == 0);
                bt.eof  = (i == len - 1);
                exp_q.push_back(bt);
            end
        end
        if (legal) exp_frames++;
        else exp_drops++;
        i_len_fifo_empty  = 1'b0;
        i_data_fifo_empty = (data_model.size() == 0);
    endtask

    // One clock cycle: observe the DUT at the falling edge, then answer its
    // requests just after the rising edge.
    task automatic step();
        logic  s_issue, s_lreq, s_xfer;
        beat_t e;
        int    lv;
        @(negedge clk);
        s_issue = o_data_fifo_r_en && !o_data_fifo_r_stop && !i_data_fifo_empty;
        s_lreq  = o_len_fifo_r_en;
        s_xfer  = o_frame_valid && i_frame_ready;
        if (o_frame_err) err_seen++;
        if (o_data_fifo_r_en) rline_seen = int'(o_data_fifo_r_line);
        if (o_len_fifo_r_en) lline_seen = int'(o_len_fifo_r_line);
        if (o_data_fifo_r_en && o_data_fifo_r_stop && o_frame_valid && !i_frame_ready) stop_seen++;
        if (s_xfer) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("beat_data", 32'(o_frame_data), 32'(e.data));
                checkOutput("beat_sof", 32'(o_frame_sof), 32'(e.sof));
                checkOutput("beat_eof", 32'(o_frame_eof), 32'(e.eof));
            end
            if (xfer_cnt == 0) first_xfer = cycle;
            last_xfer = cycle;
            xfer_cnt++;
            if (o_frame_sof && (last_eof_cycle >= 0)) sof_gap = cycle - last_eof_cycle;
            if (o_frame_eof) last_eof_cycle = cycle;
        end
        @(posedge clk);
        #1;
        cycle++;
        if (s_issue && (data_model.size() > 0)) i_data_fifo_data = data_model.pop_front();
        else i_data_fifo_data = 8'($urandom);
        i_data_fifo_empty = (data_model.size() == 0);
        i_len_fifo_r_done = 1'b0;
        if (s_lreq && (len_model.size() > 0)) begin
            lv = len_model.pop_front();
            if (!hold_done) begin
                i_len_fifo_r_done = 1'b1;
                i_len_fifo_data   = LW'(lv);
            end
        end
        i_len_fifo_empty = (len_model.size() == 0);
        case (ready_mode)
            0:       i_frame_ready = 1'b1;
            1:       i_frame_ready = !i_frame_ready;
            default: i_frame_ready = 1'($urandom);
        endcase
    endtask

    task automatic runUntilIdle(input int max_cycles, input string tag);
        int n;
        n = 0;
        step();
        while ((o_busy || (len_model.size() != 0) || (exp_q.size() != 0)) && (n < max_cycles)) begin
            step();
            n++;
        end
        checkOutput({tag, "_done_in_budget"}, 32'(n < max_cycles), 32'd1);
        step();
        step();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_stream"},
                    32'({o_frame_data, o_frame_valid, o_frame_sof, o_frame_eof, o_frame_err}), 32'd0);
        checkOutput({tag, "_counters"}, {o_frame_cnt, o_drop_cnt}, 32'd0);
        checkOutput({tag, "_fifo_ctrl"},
                    32'({o_len_fifo_r_en, o_len_fifo_r_line, o_data_fifo_r_en,
                         o_data_fifo_r_stop, o_data_fifo_r_line}), 32'd0);
        checkOutput({tag, "_busy"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        int n;
        i_rstn            = 1'b0;
        i_len_fifo_empty  = 1'b1;
        i_len_fifo_r_done = 1'b0;
        i_len_fifo_data   = '0;
        i_data_fifo_empty = 1'b1;
        i_data_fifo_data  = '0;
        i_frame_ready     = 1'b1;
        clearStats();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk);
        #1;
        i_rstn = 1'b1;

        // Minimum legal frame, incrementing bytes, consumer always ready
        $display("[TB] min-length frame");
        clearStats();
        ready_mode = 0;
        applyStimulus(64, 1'b1);
        runUntilIdle(400, "min_frame");
        checkOutput("min_frame_beats", xfer_cnt, 64);
        checkOutput("min_frame_back_to_back", last_xfer - first_xfer, 63);
        checkOutput("min_frame_cnt", 32'(o_frame_cnt), 32'd1);
        checkOutput("min_frame_r_line", rline_seen, 64);
        checkOutput("len_r_line", lline_seen, 1);
        checkOutput("min_frame_no_err", err_seen, 0);

        // Maximum legal frame with the consumer stalling every other cycle
        $display("[TB] max-length frame, toggling ready");
        clearStats();
        ready_mode = 1;
        applyStimulus(1518, 1'b0);
        runUntilIdle(4000, "max_frame");
        checkOutput("max_frame_beats", xfer_cnt, 1518);
        checkOutput("max_frame_cnt", 32'(o_frame_cnt), 32'd2);
        checkOutput("max_frame_stop_seen", 32'(stop_seen > 0), 32'd1);
        checkOutput("max_frame_data_drained", data_model.size(), 0);

        // Short frame is read out and dropped, then a good frame follows
        $display("[TB] short frame drop");
        clearStats();
        ready_mode = 0;
        applyStimulus(40, 1'b0);
        runUntilIdle(300, "drop40");
        checkOutput("drop40_no_beats", xfer_cnt, 0);
        checkOutput("drop40_err_pulses", err_seen, 1);
        checkOutput("drop40_drop_cnt", 32'(o_drop_cnt), 32'd1);
        checkOutput("drop40_lines_consumed", data_model.size(), 0);
        clearStats();
        applyStimulus(64, 1'b0);
        runUntilIdle(400, "after_drop");
        checkOutput("after_drop_beats", xfer_cnt, 64);
        checkOutput("after_drop_frame_cnt", 32'(o_frame_cnt), 32'd3);

        // Length read that never completes
        $display("[TB] length read timeout");
        clearStats();
        hold_done = 1'b1;
        len_model.push_back(64);
        exp_drops++;
        i_len_fifo_empty = 1'b0;
        for (int i = 0; i < 200; i++) step();
        checkOutput("timeout_not_early", err_seen, 0);
        checkOutput("timeout_waiting_busy", 32'(o_busy), 32'd1);
        runUntilIdle(100, "timeout");
        checkOutput("timeout_err_pulses", err_seen, 1);
        checkOutput("timeout_drop_cnt", 32'(o_drop_cnt), 32'd2);
        checkOutput("timeout_idle", 32'(o_busy), 32'd0);
        hold_done = 1'b0;

        // Reset in the middle of a 100-byte frame
        $display("[TB] mid-frame reset");
        clearStats();
        applyStimulus(100, 1'b0);
        n = 0;
        while ((xfer_cnt < 30) && (n < 300)) begin
            step();
            n++;
        end
        checkOutput("reset_point_reached", xfer_cnt, 30);
        i_rstn = 1'b0;
        step();
        data_model.delete();
        len_model.delete();
        exp_q.delete();
        exp_frames        = 0;
        exp_drops         = 0;
        i_len_fifo_empty  = 1'b1;
        i_data_fifo_empty = 1'b1;
        i_len_fifo_r_done = 1'b0;
        @(negedge clk);
        checkAllZero("midreset");
        @(posedge clk);
        #1;
        i_rstn = 1'b1;
        clearStats();
        applyStimulus(64, 1'b0);
        runUntilIdle(400, "post_reset");
        checkOutput("post_reset_beats", xfer_cnt, 64);
        checkOutput("post_reset_frame_cnt", 32'(o_frame_cnt), 32'd1);
        checkOutput("post_reset_drop_cnt", 32'(o_drop_cnt), 32'd0);
        checkOutput("post_reset_no_err", err_seen, 0);

        // Back-to-back frames. After the eof beat: IDLE, LEN_REQ, LEN_WAIT
        // (length returns next cycle), CHECK, first request, line return,
        // so the next sof is presented 7 cycles after the eof beat.
        $display("[TB] back-to-back frames");
        clearStats();
        applyStimulus(64, 1'b1);
        applyStimulus(64, 1'b0);
        runUntilIdle(600, "b2b");
        checkOutput("b2b_beats", xfer_cnt, 128);
        checkOutput("b2b_sof_gap", sof_gap, 7);
        checkOutput("b2b_frame_cnt", 32'(o_frame_cnt), 32'd3);

        // Length boundaries plus random lengths under random backpressure
        $display("[TB] boundary and random frames");
        clearStats();
        ready_mode = 2;
        applyStimulus(63, 1'b0);
        applyStimulus(1519, 1'b0);
        applyStimulus(65, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(int'($urandom_range(20, 140)), 1'b0);
        runUntilIdle(8000, "random");
        checkOutput("random_frame_cnt", 32'(o_frame_cnt), exp_frames);
        checkOutput("random_drop_cnt", 32'(o_drop_cnt), exp_drops);
        checkOutput("random_err_pulses", err_seen, exp_drops);
        checkOutput("random_data_drained", data_model.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
